// File: rtl/cpu_pkg.sv
// Shared fetch-stage widths, instruction field positions, halt opcode and FSM states.
// Imported by the fetch interface, the prefetch queue and the fetch stage top.
package cpu_pkg;

   localparam int PC_W   = 12;
   localparam int INST_W = 16;
   localparam int OPC_W  = 4;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RA_MSB  = 11;
   localparam int RA_LSB  = 8;
   localparam int RB_MSB  = 7;
   localparam int RB_LSB  = 4;
   localparam int RC_MSB  = 3;
   localparam int RC_LSB  = 0;

   localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
      return inst[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response plus decode-side head and redirect.
// master = fetch stage, slave = memory/decode environment.
interface fetch_stage_if;
   import cpu_pkg::*;

   logic              stall;
   logic              branchD;
   logic [PC_W-1:0]   PC_branch;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_valid;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [INST_W-1:0] i_inst;
   logic [PC_W-1:0]   pcD;

   modport master (
      input  stall, branchD, PC_branch, imem_valid, imem_rdata,
      output imem_req, imem_addr, inst_valid, i_inst, pcD
   );

   modport slave (
      output stall, branchD, PC_branch, imem_valid, imem_rdata,
      input  imem_req, imem_addr, inst_valid, i_inst, pcD
   );

endinterface

// File: rtl/fetch_queue.sv
// Purpose: DEPTH-entry synchronous FIFO of {pc, inst}; clear beats push and pop.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  fetch_entry_t     push_dat,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output logic             head_vld,
   output fetch_entry_t     head_dat
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            empty;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CNT_W'(1);
         else if (do_pop && !do_push)
            count <= count - CNT_W'(1);
      end
   end

   // Payload storage needs no reset; validity lives entirely in count.
   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= push_dat;
   end

   assign head_vld = !empty;
   assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch front end; single-outstanding imem requests into a prefetch queue, flushed on branchD. Optional FETCH_HALT_EN adds halted.
// Latency: request issues combinationally from IDLE; a returned word reaches decode one cycle after imem_valid.
// Backpressure: stall holds the queue head; no request issues while the queue is full.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                DEPTH    = 2,
   parameter logic [PC_W-1:0]   RESET_PC = 12'h000,
   parameter logic [INST_W-1:0] NOP_INST = 16'h0000
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master fif
`ifdef FETCH_HALT_EN
   ,
   output logic          halted
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_state_t      state;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   req_pc;
   logic [CNT_W-1:0]  q_count;
   logic              q_head_vld;
   fetch_entry_t      q_head;
   fetch_entry_t      push_dat;
   logic              issue;
   logic              push;
   logic              pop;
   logic              halt_block;

   // Space is judged on the current count only; a same-cycle pop does not open a slot.
   assign issue = reset && (state == IDLE) && (q_count < CNT_W'(DEPTH))
                  && !fif.branchD && !halt_block;
   assign push     = (state == WAIT) && fif.imem_valid && !fif.branchD;
   assign pop      = q_head_vld && !fif.stall && !fif.branchD;
   assign push_dat = {req_pc, fif.imem_rdata};

   assign fif.imem_req   = issue;
   assign fif.imem_addr  = pc;
   assign fif.inst_valid = q_head_vld;
   assign fif.i_inst     = q_head_vld ? q_head.inst : NOP_INST;
   assign fif.pcD        = q_head_vld ? q_head.pc   : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fif.branchD) begin
                  pc <= fif.PC_branch;
               end else if (issue) begin
                  req_pc <= pc;
                  pc     <= pc + PC_W'(1);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (fif.branchD) begin
                  pc    <= fif.PC_branch;
                  state <= fif.imem_valid ? IDLE : DRAIN;
               end else if (fif.imem_valid) begin
                  state <= IDLE;
               end
            end
            DRAIN: begin
               if (fif.branchD)    pc    <= fif.PC_branch;
               if (fif.imem_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FETCH_HALT_EN
   assign halt_block = halted;

   always_ff @(posedge clk) begin
      if (!reset)
         halted <= 1'b0;
      else if (fif.branchD)
         halted <= 1'b0;
      else if (push && (opcode_of(fif.imem_rdata) == HALT_OPC))
         halted <= 1'b1;
   end
`else
   assign halt_block = 1'b0;
`endif

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk      (clk),
      .reset    (reset),
      .clear    (fif.branchD),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .count    (q_count),
      .head_vld (q_head_vld),
      .head_dat (q_head)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// sequence-level model of what decode should see and what memory should be asked for.
module tb_fetch_stage;
   import cpu_pkg::*;

   localparam int                DEPTH    = 2;
   localparam logic [PC_W-1:0]   RESET_PC = 12'h000;
   localparam logic [INST_W-1:0] NOP      = 16'h0000;

   logic clk;
   logic rst_n;
   fetch_stage_if fif ();
`ifdef FETCH_HALT_EN
   logic halted;
`endif

   fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
      .clk   (clk),
      .reset (rst_n),
      .fif   (fif)
`ifdef FETCH_HALT_EN
      ,
      .halted(halted)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks;
   int n_fail;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // memory responder state
   bit              mem_out;
   int              mem_cnt;
   logic [PC_W-1:0] mem_addr;
   int              lat_fixed;
   bit              lat_rand;
   bit              halt_word;

   function automatic logic [INST_W-1:0] memfn(input logic [PC_W-1:0] a);
      if (halt_word && a == 12'h003) return 16'hF000;
      return 16'h1000 + {4'h0, a};
   endfunction

   // One clock: apply inputs at negedge, answer memory, then capture any new request.
   task automatic cycle(input logic r, input logic s, input logic b, input logic [PC_W-1:0] tgt);
      @(negedge clk);
      rst_n         = r;
      fif.stall     = s;
      fif.branchD   = b;
      fif.PC_branch = tgt;
      if (!r) begin
         mem_out        = 1'b0;
         fif.imem_valid = 1'b0;
      end else if (mem_out && mem_cnt <= 1) begin
         fif.imem_valid = 1'b1;
         fif.imem_rdata = memfn(mem_addr);
         mem_out        = 1'b0;
      end else begin
         fif.imem_valid = 1'b0;
         if (mem_out) mem_cnt--;
      end
      #1;
      if (r && fif.imem_req) begin
         mem_out  = 1'b1;
         mem_addr = fif.imem_addr;
         mem_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
      end
   endtask

   // Scoreboard: expected decode heads in order, next expected request address.
   fetch_entry_t    exp_q[$];
   logic [PC_W-1:0] gen_pc;
   logic [PC_W-1:0] exp_req_pc;
   bit              pend;
   bit              stale;
   bit              m_push;
   bit              m_pop;
   int              pops;

   always @(negedge clk) begin
      #2;
      if (rst_n !== 1'b1) begin
         exp_q.delete();
         gen_pc     = RESET_PC;
         exp_req_pc = RESET_PC;
         pend       = 1'b0;
         stale      = 1'b0;
      end else begin
         if (exp_q.size() == 0) begin
            chk("empty_valid", fif.inst_valid, 0);
            chk("empty_inst", fif.i_inst, NOP);
            chk("empty_pc", fif.pcD, 0);
         end else begin
            chk("head_valid", fif.inst_valid, 1);
            chk("head_pc", fif.pcD, exp_q[0].pc);
            chk("head_inst", fif.i_inst, exp_q[0].inst);
         end
         if (fif.imem_req) begin
            chk("req_addr", fif.imem_addr, exp_req_pc);
            chk("req_has_space", exp_q.size() < DEPTH, 1);
            chk("req_single_outstanding", pend, 0);
            chk("req_not_on_redirect", fif.branchD, 0);
            exp_req_pc = exp_req_pc + 12'd1;
         end
         m_push = fif.imem_valid && !fif.branchD && !stale;
         m_pop  = (exp_q.size() > 0) && !fif.stall && !fif.branchD;
         if (fif.branchD) begin
            exp_q.delete();
            gen_pc     = fif.PC_branch;
            exp_req_pc = fif.PC_branch;
         end else begin
            if (m_pop) begin
               void'(exp_q.pop_front());
               pops++;
            end
            if (m_push) begin
               exp_q.push_back('{pc: gen_pc, inst: memfn(gen_pc)});
               gen_pc = gen_pc + 12'd1;
            end
         end
         if (fif.imem_valid) begin
            pend  = 1'b0;
            stale = 1'b0;
         end else if (fif.branchD && pend) begin
            stale = 1'b1;
         end
         if (fif.imem_req) pend = 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [PC_W-1:0] wrap_exp [4];
   bit              found;
   bit              bad;
   int              idx;
   logic            r_s;
   logic            r_b;
   logic [PC_W-1:0] r_t;

   initial begin
      n_checks = 0; n_fail = 0; pops = 0;
      rst_n = 1'b0;
      fif.stall = 1'b0; fif.branchD = 1'b0; fif.PC_branch = '0;
      fif.imem_valid = 1'b0; fif.imem_rdata = '0;
      mem_out = 1'b0; mem_cnt = 0; mem_addr = '0;
      lat_fixed = 1; lat_rand = 1'b0; halt_word = 1'b0;

      // reset values and first-word latency
      repeat (3) cycle(0, 0, 0, 12'h0);
      chk("rst_req", fif.imem_req, 0);
      chk("rst_valid", fif.inst_valid, 0);
      chk("rst_inst", fif.i_inst, NOP);
      chk("rst_pc", fif.pcD, 0);
      cycle(1, 0, 0, 12'h0);
      chk("first_req", fif.imem_req, 1);
      chk("first_addr", fif.imem_addr, 12'h000);
      cycle(1, 0, 0, 12'h0);
      chk("first_valid_c1", fif.inst_valid, 0);
      cycle(1, 0, 0, 12'h0);
      chk("first_valid_c2", fif.inst_valid, 1);
      chk("first_pc", fif.pcD, 12'h000);
      chk("first_inst", fif.i_inst, 16'h1000);
      repeat (12) cycle(1, 0, 0, 12'h0);

      // stall fills the queue, then no more requests
      repeat (2) cycle(0, 0, 0, 12'h0);
      for (int k = 0; k < 7; k++) begin
         cycle(1, 1, 0, 12'h0);
         if (k >= 4) chk("full_no_req", fif.imem_req, 0);
      end
      chk("full_valid", fif.inst_valid, 1);
      chk("full_head_pc", fif.pcD, 12'h000);
      cycle(1, 0, 0, 12'h0);
      chk("full_pop_head", fif.pcD, 12'h000);
      cycle(1, 0, 0, 12'h0);
      chk("second_entry_pc", fif.pcD, 12'h001);
      chk("second_entry_inst", fif.i_inst, 16'h1001);
      repeat (6) cycle(1, 0, 0, 12'h0);

      // redirect coinciding with a response and a pop
      repeat (2) cycle(0, 0, 0, 12'h0);
      repeat (3) cycle(1, 1, 0, 12'h0);
      cycle(1, 0, 1, 12'h100);
      chk("redir_pop_valid", fif.inst_valid, 1);
      cycle(1, 0, 0, 12'h0);
      chk("redir_flush_valid", fif.inst_valid, 0);
      chk("redir_flush_inst", fif.i_inst, NOP);
      chk("redir_flush_pc", fif.pcD, 0);
      chk("redir_next_req", fif.imem_req, 1);
      chk("redir_next_addr", fif.imem_addr, 12'h100);
      repeat (6) cycle(1, 0, 0, 12'h0);

      // slow memory, redirect while a request is outstanding
      repeat (2) cycle(0, 0, 0, 12'h0);
      lat_fixed = 3;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cycle(1, 0, 0, 12'h0);
         if (fif.imem_req && fif.imem_addr == 12'h005) begin
            found = 1'b1;
            break;
         end
      end
      chk("found_req_005", found, 1);
      cycle(1, 0, 1, 12'h040);
      found = 1'b0; bad = 1'b0;
      for (int i = 0; i < 60; i++) begin
         cycle(1, 0, 0, 12'h0);
         if (fif.inst_valid && (fif.pcD == 12'h005 || fif.pcD == 12'h006)) bad = 1'b1;
         if (fif.imem_req && !found) begin
            found = 1'b1;
            chk("drain_next_addr", fif.imem_addr, 12'h040);
         end
      end
      chk("drain_req_seen", found, 1);
      chk("drain_no_stale_pc", bad, 0);

      // PC wrap
      lat_fixed = 1;
      cycle(1, 0, 1, 12'hFFE);
      wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;
      idx = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(1, 0, 0, 12'h0);
         if (fif.imem_req) begin
            chk("wrap_addr", fif.imem_addr, wrap_exp[idx]);
            idx++;
            if (idx == 4) break;
         end
      end
      chk("wrap_count", idx, 4);

      // randomized run with one mid-stream reset
      lat_rand = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         r_s = ($urandom_range(0, 9) < 3);
         r_b = ($urandom_range(0, 24) == 0);
         r_t = ($urandom_range(0, 3) == 0) ? (12'hFFC + 12'($urandom_range(0, 3))) : 12'($urandom);
         cycle((i == 700 || i == 701) ? 1'b0 : 1'b1, r_s, r_b, r_t);
      end
      lat_rand = 1'b0;

`ifdef FETCH_HALT_EN
      // halt opcode stops fetch; redirect resumes
      repeat (2) cycle(0, 0, 0, 12'h0);
      halt_word = 1'b1;
      lat_fixed = 1;
      pops = 0;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cycle(1, 0, 0, 12'h0);
         if (fif.imem_req && fif.imem_addr > 12'h003) bad = 1'b1;
      end
      chk("halt_set", halted, 1);
      chk("halt_no_req_past_003", bad, 0);
      chk("halt_words_decoded", pops, 4);
      cycle(1, 0, 1, 12'h010);
      cycle(1, 0, 0, 12'h0);
      chk("halt_cleared", halted, 0);
      chk("halt_resume_req", fif.imem_req, 1);
      chk("halt_resume_addr", fif.imem_addr, 12'h010);
      repeat (6) cycle(1, 0, 0, 12'h0);
      halt_word = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch front end of the 16-bit pipeline. It supplies the decode stage with `i_inst` and `pcD`, and accepts branch redirects (`branchD`/`PC_branch`) back from decode.
- Holds the 12-bit PC.
- Issues single-outstanding requests to instruction memory.
- Buffers returned words in a small prefetch queue.
- Flushes the queue on redirect.

Parameters:
DEPTH, 2, prefetch queue entries (power of two, ≥2)
RESET_PC, 12'h000, PC loaded on reset
NOP_INST, 16'h0000, instruction word driven when the queue is empty

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  synchronous, active-low reset (0 = reset)
stall  input  1  decode holds its current instruction; no pop
branchD  input  1  redirect strobe from decode
PC_branch  input  12  redirect target
imem_req  output  1  request strobe, one cycle per request
imem_addr  output  12  word address, valid while imem_req=1
imem_valid  input  1  response strobe
imem_rdata  input  16  response word, valid with imem_valid
inst_valid  output  1  queue head is valid
i_inst  output  16  queue head instruction, or NOP_INST when empty
pcD  output  12  PC of the queue head, or 0 when empty

Behaviour:
- Reset (`reset`=0 at a clk edge):
  - PC=RESET_PC, queue empty, FSM=IDLE.
  - imem_req=0, inst_valid=0, i_inst=NOP_INST, pcD=0.
  - Reset mid-request abandons the response. The memory must also be reset.
- FSM states:
  - IDLE → WAIT: when (queue count + 0 in flight) < DEPTH and no redirect this cycle. Drive imem_req=1 and imem_addr=PC for exactly that cycle; PC <= PC+1, wrapping 12'hFFF→12'h000.
  - WAIT → IDLE: on imem_valid. Push {imem_rdata, the PC captured for that request} into the queue. Next request issues no earlier than the following cycle.
  - WAIT → DRAIN: on branchD. The outstanding response becomes stale.
  - DRAIN → IDLE: on imem_valid. The response is discarded, not pushed.
- Memory latency is ≥1 cycle and unbounded. At most one request is outstanding.
- Pop: when inst_valid=1 and stall=0, the head is consumed at the clock edge. Push and pop may occur in the same cycle; count is unchanged.
- Full: a request issues only if count < DEPTH at issue time. A response always finds space.
- Empty: inst_valid=0, i_inst=NOP_INST, pcD=0. stall is ignored.
- Outputs are combinational from the registered queue head. A pushed word reaches decode one cycle after imem_valid.
- Redirect (branchD=1):
  - Queue cleared.
  - PC <= PC_branch.
  - Any response arriving in the same cycle is dropped.
  - No request issues in that cycle.
  - Redirect overrides stall and any pop.
- Redirect while in DRAIN: PC is updated again and the FSM stays in DRAIN.
- Redirect in IDLE: the first request uses PC_branch in the next cycle.

Optional Feature:
Macro FETCH_HALT_EN.
- When defined:
  - Add output `halted` (1 bit, reset 0).
  - When a pushed word has opcode [15:12]=4'hF, set halted=1 and issue no further requests.
  - Words already queued still drain to decode.
  - branchD clears halted and redirects normally.
- When undefined: there is no halted port, and 4'hF is fetched like any other opcode.

Decomposition:
- Shared package `cpu_pkg`:
  - Width constants PC_W=12, INST_W=16, OPC_W=4.
  - Opcode field positions [15:12], [11:8], [7:4], [3:0].
  - HALT_OPC=4'hF.
  - FSM state enum {IDLE, WAIT, DRAIN}.
- Sub-module `fetch_queue`: a DEPTH-entry synchronous FIFO of {pc, inst} with push, pop, clear, count, head outputs. Clear has priority over push and pop.

Test Plan:
- Reset then 1-cycle memory with mem[a]=16'h1000+a, stall=0: decode sees PCs 000,001,002… with i_inst 1000,1001,1002, and inst_valid first high 2 cycles after reset release.
- stall=1 held for 6 cycles with DEPTH=2: exactly 2 entries accumulate, imem_req stays 0 while full, and the head is unchanged (pc 000).
- 3-cycle memory latency with branchD=1 and PC_branch=12'h040 one cycle after a request to 12'h005: the 005 response is discarded and the next imem_addr=040. No pcD of 005 or 006 is ever presented.
- Redirect in the same cycle as imem_valid and a pop: the queue is empty the next cycle, inst_valid=0 and i_inst=NOP_INST, followed by a request to the target.
- PC=12'hFFE, free-running: imem_addr sequence FFE, FFF, 000, 001.
- FETCH_HALT_EN defined, mem[003]=16'hF000: halted=1 after 003 is pushed. No request beyond 003. Words 000–003 reach decode. A branchD to 12'h010 clears halted and resumes fetch at 010.
